// File: rtl/vend_pkg.sv
// Shared types, coin encodings and helpers for the parametrised vending FSM.
// Optional sales counter is enabled by defining VEND_SALES_COUNT_EN.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_SEL_A = 2'b01;
  localparam logic [1:0] COIN_SEL_B = 2'b10;
  localparam logic [1:0] COIN_SEL_C = 2'b11;

  localparam int unsigned SALES_W = 16;

  // Credit units carried by a coin selector; the invalid selector is worth nothing.
  function automatic int unsigned coin_units(input logic [1:0] sel,
                                             input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
    case (sel)
      COIN_SEL_A: return a;
      COIN_SEL_B: return b;
      COIN_SEL_C: return c;
      default:    return 0;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_fsm_if.sv
// Coin-acceptor / dispenser bundle for vend_fsm. master = acceptor side, slave = FSM.
// sales_count exists only when VEND_SALES_COUNT_EN is defined.
interface vend_fsm_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                cancel;
  logic                vend;
  logic                change_pulse;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
`ifdef VEND_SALES_COUNT_EN
  logic [15:0]         sales_count;
`endif

  modport master (
`ifdef VEND_SALES_COUNT_EN
    input  sales_count,
`endif
    output coin_valid, coin_sel, cancel,
    input  vend, change_pulse, coin_reject, busy, credit
  );

  modport slave (
`ifdef VEND_SALES_COUNT_EN
    output sales_count,
`endif
    input  coin_valid, coin_sel, cancel,
    output vend, change_pulse, coin_reject, busy, credit
  );
endinterface

// File: rtl/vend_coin_decode.sv
// Combinational coin classifier: valid coin -> accept + credit units, selector 00 -> bad.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int unsigned COIN_A   = 1,
  parameter int unsigned COIN_B   = 2,
  parameter int unsigned COIN_C   = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  output logic                accept_c,
  output logic                bad_c,
  output logic [CREDIT_W-1:0] units_c
);

  assign accept_c = coin_valid && (coin_sel != COIN_NONE);
  assign bad_c    = coin_valid && (coin_sel == COIN_NONE);
  assign units_c  = CREDIT_W'(coin_units(coin_sel, COIN_A, COIN_B, COIN_C));

endmodule

// File: rtl/vend_fsm.sv
// Parametrised vending FSM: credit accumulation, single-cycle vend, serial change/refund.
// Define VEND_SALES_COUNT_EN to add the 16-bit wrapping sales_count output.
module vend_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned COIN_A   = 1,
  parameter int unsigned COIN_B   = 2,
  parameter int unsigned COIN_C   = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic     clk,
  input  logic     reset,
  vend_fsm_if.slave bus
);

  localparam int unsigned COIN_MAX   = max3(COIN_A, COIN_B, COIN_C);
  localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;
  localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);

  if (PRICE < 1) begin : g_price_chk
    $error("vend_fsm: PRICE must be >= 1");
  end
  if (CREDIT_MAX < PRICE - 1 + COIN_MAX) begin : g_width_chk
    $error("vend_fsm: CREDIT_W too narrow for PRICE and coin values");
  end

  logic                accept_c;
  logic                bad_c;
  logic [CREDIT_W-1:0] units_c;

  vend_coin_decode #(
    .COIN_A  (COIN_A),
    .COIN_B  (COIN_B),
    .COIN_C  (COIN_C),
    .CREDIT_W(CREDIT_W)
  ) u_decode (
    .coin_valid(bus.coin_valid),
    .coin_sel  (bus.coin_sel),
    .accept_c  (accept_c),
    .bad_c     (bad_c),
    .units_c   (units_c)
  );

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_q, credit_next;
  logic                reject_q, reject_next;
  logic                vend_q, vend_next;
  logic                change_q, change_next;
  logic                busy_q, busy_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      credit_q <= credit_next;
      reject_q <= reject_next;
      vend_q   <= vend_next;
      change_q <= change_next;
      busy_q   <= busy_next;
    end
  end

  // Cancel only matters in COLLECT; in IDLE it is ignored and a coin is still taken.
  always_comb begin
    state_next  = state;
    credit_next = credit_q;
    reject_next = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if ((state == COLLECT) && bus.cancel) begin
          state_next  = CHANGE;
          reject_next = bus.coin_valid;
        end else if (accept_c) begin
          credit_next = credit_q + units_c;
          state_next  = (credit_next >= PRICE_U) ? VEND : COLLECT;
        end else if (bad_c) begin
          reject_next = 1'b1;
        end
      end
      VEND: begin
        reject_next = bus.coin_valid;
        credit_next = credit_q - PRICE_U;
        state_next  = (credit_next != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_next = bus.coin_valid;
        credit_next = credit_q - CREDIT_W'(1);
        state_next  = (credit_next == '0) ? IDLE : CHANGE;
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
    vend_next   = (state_next == VEND);
    change_next = (state_next == CHANGE);
    busy_next   = vend_next || change_next;
  end

  assign bus.vend         = vend_q;
  assign bus.change_pulse = change_q;
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = busy_q;
  assign bus.credit       = credit_q;

`ifdef VEND_SALES_COUNT_EN
  logic [SALES_W-1:0] sales_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sales_q <= '0;
    end else if (state == VEND) begin
      sales_q <= sales_q + SALES_W'(1);
    end
  end

  assign bus.sales_count = sales_q;
`endif

endmodule
